// File: rtl/bus_mem_responder.sv
// Memory-side bus target: serves 16-bit word reads/writes from a local array with
// programmable read wait states, bus-lock freeze and out-of-range error responses.
module bus_mem_responder #(
    parameter logic [15:0] BASE_ADDR    = 16'h0000,
    parameter int unsigned DEPTH_LOG2   = 8,
    parameter int unsigned READ_LATENCY = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] i_addr_bus,
    input  logic        i_addr_enable,
    input  logic        i_rw_bus,
    input  logic [15:0] i_data_bus,
    input  logic        i_lock,
    output logic        o_ready,
    output logic        o_ack,
    output logic        o_err,
    output logic        o_data_enable,
    output logic [15:0] o_data_bus
);

    localparam int unsigned AW    = 16;
    localparam int unsigned DW    = 16;
    localparam int unsigned CW    = 4;
    localparam int unsigned DEPTH = 1 << DEPTH_LOG2;

    typedef enum logic [1:0] {IDLE, WAIT, RESP, ERR} state_t;

    state_t                state;
    logic [CW-1:0]         wait_cnt;
    logic [DEPTH_LOG2-1:0] cap_idx;
    logic [DW-1:0]         mem [DEPTH];

    logic [AW-1:0]         offset;
    logic [DEPTH_LOG2-1:0] req_idx;
    logic                  in_range;
    logic                  accept;
    logic                  mem_we;

    // Wrapping offset from the window base; index is truncated only after the range test.
    assign offset   = i_addr_bus - BASE_ADDR;
    assign in_range = 32'(offset) < DEPTH;
    assign req_idx  = offset[DEPTH_LOG2-1:0];

    assign o_ready = (state != WAIT) & ~i_lock;
    assign accept  = o_ready & i_addr_enable;
    assign mem_we  = accept & in_range & i_rw_bus & ~rst;

    // Writes commit at the accepting edge; the array itself has no reset.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[req_idx] <= i_data_bus;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= IDLE;
            wait_cnt      <= '0;
            cap_idx       <= '0;
            o_ack         <= 1'b0;
            o_err         <= 1'b0;
            o_data_enable <= 1'b0;
            o_data_bus    <= '0;
        end else if (accept) begin
            cap_idx       <= req_idx;
            o_ack         <= 1'b0;
            o_err         <= 1'b0;
            o_data_enable <= 1'b0;
            o_data_bus    <= '0;
            if (!in_range) begin
                state <= ERR;
                o_err <= 1'b1;
            end else if (i_rw_bus) begin
                state <= RESP;
                o_ack <= 1'b1;
            end else if (READ_LATENCY == 0) begin
                state         <= RESP;
                o_ack         <= 1'b1;
                o_data_enable <= 1'b1;
                o_data_bus    <= mem[req_idx];
            end else begin
                state    <= WAIT;
                wait_cnt <= CW'(READ_LATENCY - 1);
            end
        end else if (!i_lock) begin
            // Lock freezes every state; otherwise advance the pending access.
            case (state)
                WAIT: begin
                    if (wait_cnt == '0) begin
                        state         <= RESP;
                        o_ack         <= 1'b1;
                        o_data_enable <= 1'b1;
                        o_data_bus    <= mem[cap_idx];
                    end else begin
                        wait_cnt <= wait_cnt - CW'(1);
                    end
                end
                RESP, ERR: begin
                    state         <= IDLE;
                    o_ack         <= 1'b0;
                    o_err         <= 1'b0;
                    o_data_enable <= 1'b0;
                    o_data_bus    <= '0;
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bus_mem_responder.sv
// Randomized scoreboard bench for bus_mem_responder: two instances (base 0/latency 2 and
// base 0x0100/latency 0) checked against a word-level model of the memory window.
module tb_bus_mem_responder;

    localparam int unsigned NI    = 2;
    localparam int unsigned DEPTH = 256;

    typedef struct {
        logic        err;
        logic        rd;
        logic [15:0] data;
        int          lat;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] addr_bus [NI];
    logic [15:0] data_bus [NI];
    logic [15:0] rdata    [NI];
    logic        en       [NI];
    logic        rw       [NI];
    logic        lock     [NI];
    logic        ready    [NI];
    logic        ack      [NI];
    logic        err      [NI];
    logic        de       [NI];
    bit          dir_lock [NI];
    bit          rnd_lock [NI];

    exp_t        exp_q [NI][$];
    logic [15:0] mdl   [NI][DEPTH];
    int          checks = 0;
    int          errors = 0;
    int          rand_lock_k = -1;

    always #5 clk = ~clk;

    function automatic logic [15:0] base_of(input int k);
        return (k == 0) ? 16'h0000 : 16'h0100;
    endfunction

    function automatic int lat_of(input int k);
        return (k == 0) ? 2 : 0;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, expv, $time);
        end
    endtask

    generate
        for (genvar g = 0; g < NI; g++) begin : gi
            assign lock[g] = dir_lock[g] | rnd_lock[g];

            bus_mem_responder #(
                .BASE_ADDR   (g == 0 ? 16'h0000 : 16'h0100),
                .DEPTH_LOG2  (8),
                .READ_LATENCY(g == 0 ? 2 : 0)
            ) dut (
                .clk          (clk),
                .rst          (rst),
                .i_addr_bus   (addr_bus[g]),
                .i_addr_enable(en[g]),
                .i_rw_bus     (rw[g]),
                .i_data_bus   (data_bus[g]),
                .i_lock       (lock[g]),
                .o_ready      (ready[g]),
                .o_ack        (ack[g]),
                .o_err        (err[g]),
                .o_data_enable(de[g]),
                .o_data_bus   (rdata[g])
            );

            bit busy  = 1'b0;
            bit seen  = 1'b0;
            int edges = 0;

            // Monitor: tracks one outstanding access, counting unlocked edges since acceptance.
            always @(negedge clk) begin : mon
                exp_t e;
                logic vis;
                logic exp_rdy;
                if (rst) begin
                    chk($sformatf("reset_out%0d", g), {ready[g], ack[g], err[g], de[g], rdata[g]},
                        {1'b1, 1'b0, 1'b0, 1'b0, 16'h0});
                    exp_q[g].delete();
                    busy = 1'b0;
                end else begin
                    vis     = ack[g] | err[g];
                    exp_rdy = ~lock[g] & ~(busy & ~vis);
                    chk($sformatf("ready%0d", g), 32'(ready[g]), 32'(exp_rdy));
                    if (busy && vis) begin
                        chk($sformatf("queue_nonempty%0d", g), 32'(exp_q[g].size() != 0), 1);
                        if (exp_q[g].size() != 0) begin
                            e = exp_q[g][0];
                            chk($sformatf("resp%0d", g), {ack[g], err[g], de[g], rdata[g]},
                                {~e.err, e.err, e.rd & ~e.err, (e.rd & ~e.err) ? e.data : 16'h0});
                            if (!seen) begin
                                chk($sformatf("latency%0d", g), edges, e.lat);
                                seen = 1'b1;
                            end
                            if (!lock[g]) begin
                                void'(exp_q[g].pop_front());
                                busy = 1'b0;
                            end
                        end
                    end else begin
                        chk($sformatf("quiet%0d", g), {ack[g], err[g], de[g], rdata[g]}, 0);
                        if (busy && !lock[g]) edges++;
                    end
                    if (exp_rdy && en[g]) begin
                        busy  = 1'b1;
                        seen  = 1'b0;
                        edges = 1;
                    end
                end
            end
        end
    endgenerate

    always @(posedge clk) begin
        #1;
        for (int k = 0; k < NI; k++) begin
            rnd_lock[k] = (k == rand_lock_k) && ($urandom_range(0, 5) == 0);
        end
    end

    // Pushes the model's expectation, then holds the request until it is accepted.
    task automatic issue(input int k, input logic [15:0] a, input logic w, input logic [15:0] d);
        exp_t        e;
        logic [15:0] off;
        bit          ok;
        ok     = 1'b0;
        off    = a - base_of(k);
        e.err  = (off >= 16'(DEPTH));
        e.rd   = ~w;
        e.data = e.err ? 16'h0 : mdl[k][off[7:0]];
        e.lat  = (e.err || w) ? 1 : lat_of(k) + 1;
        if (!e.err && w) mdl[k][off[7:0]] = d;
        exp_q[k].push_back(e);
        addr_bus[k] = a;
        rw[k]       = w;
        data_bus[k] = d;
        en[k]       = 1'b1;
        for (int n = 0; n < 200 && !ok; n++) begin
            @(negedge clk);
            if (ready[k]) ok = 1'b1;
        end
        if (!ok) begin
            chk($sformatf("accept_timeout%0d", k), 32'(ready[k]), 1);
            void'(exp_q[k].pop_back());
            en[k] = 1'b0;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int k, input int n);
        en[k] = 1'b0;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic drain(input int k);
        for (int n = 0; n < 100 && exp_q[k].size() != 0; n++) @(posedge clk);
        #1;
        chk($sformatf("drain%0d", k), exp_q[k].size(), 0);
    endtask

    initial begin
        int n_ack;
        logic [15:0] a;
        for (int k = 0; k < NI; k++) begin
            en[k] = 1'b0; rw[k] = 1'b0; addr_bus[k] = '0; data_bus[k] = '0;
        end
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;

        // Fill both arrays so every later read has a known value.
        for (int k = 0; k < NI; k++) begin
            for (int i = 0; i < DEPTH; i++) issue(k, base_of(k) + 16'(i), 1'b1, 16'($urandom));
            idle(k, 1);
            drain(k);
        end

        issue(0, 16'h0010, 1'b1, 16'hBEEF);
        idle(0, 1);
        issue(0, 16'h0010, 1'b0, 16'h0);
        idle(0, 0);
        drain(0);

        issue(1, 16'h0101, 1'b0, 16'h0);
        issue(1, 16'h0102, 1'b0, 16'h0);
        issue(1, 16'h0103, 1'b1, 16'h1234);
        issue(1, 16'h0103, 1'b0, 16'h0);
        idle(1, 0);
        drain(1);
        issue(0, 16'h0001, 1'b0, 16'h0);
        issue(0, 16'h0002, 1'b0, 16'h0);
        idle(0, 0);
        drain(0);

        issue(1, 16'h00FF, 1'b0, 16'h0);
        issue(1, 16'h0200, 1'b0, 16'h0);
        issue(1, 16'h01FF, 1'b0, 16'h0);
        idle(1, 0);
        drain(1);

        // Lock 3 cycles in the wait phase, then 2 cycles while the ack is showing.
        issue(0, 16'h0020, 1'b0, 16'h0);
        en[0] = 1'b0;
        dir_lock[0] = 1'b1;
        repeat (3) begin @(posedge clk); #1; end
        dir_lock[0] = 1'b0;
        repeat (2) begin @(posedge clk); #1; end
        dir_lock[0] = 1'b1;
        n_ack = 0;
        repeat (2) begin
            @(negedge clk);
            if (ack[0]) n_ack++;
            @(posedge clk);
            #1;
        end
        dir_lock[0] = 1'b0;
        @(negedge clk);
        if (ack[0]) n_ack++;
        chk("lock_stretch", n_ack, 3);
        @(posedge clk);
        #1;
        drain(0);

        // Reset mid-wait drops the read; reset during a write ack keeps the write.
        issue(0, 16'h0030, 1'b0, 16'h0);
        en[0] = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        repeat (3) begin @(posedge clk); #1; end
        rst = 1'b0;
        issue(0, 16'h0031, 1'b1, 16'h5A5A);
        en[0] = 1'b0;
        rst = 1'b1;
        repeat (3) begin @(posedge clk); #1; end
        rst = 1'b0;
        issue(0, 16'h0030, 1'b0, 16'h0);
        issue(0, 16'h0031, 1'b0, 16'h0);
        idle(0, 0);
        drain(0);

        for (int k = 0; k < NI; k++) begin
            issue(k, 16'hFFFF, 1'b1, 16'hDEAD);
            for (int i = 0; i < DEPTH; i++) issue(k, base_of(k) + 16'(i), 1'b0, 16'h0);
            idle(k, 0);
            drain(k);
        end

        for (int k = 0; k < NI; k++) begin
            rand_lock_k = k;
            for (int i = 0; i < 300; i++) begin
                if ($urandom_range(0, 9) < 8) a = base_of(k) + 16'($urandom_range(0, 255));
                else a = 16'($urandom);
                issue(k, a, 1'($urandom_range(0, 1)), 16'($urandom));
                if ($urandom_range(0, 3) == 0) idle(k, $urandom_range(0, 2));
            end
            rand_lock_k = -1;
            idle(k, 2);
            drain(k);
        end

        idle(0, 3);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog expired at t=%0t", $time);
        $fatal(1);
    end

endmodule
